cmd_uart_responder: RTL and testbench
=====================================

Name: cmd_uart_responder

Overview:
- DUT-side endpoint of the serial command link driven by the bench's command-send and ack-check tasks.
- Receives 8N1 UART bytes on RX, pairs them (high byte first) into a 16-bit command, and presents it to the command processor with a ready flag.
- Transmits a one-byte response (normally positive ack 8'hA5) on TX when the command processor requests it.

Parameters:
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); minimum 8.
- POS_ACK, 8'hA5, default response byte exported for the command processor and the bench.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- RX  input  1  asynchronous serial in, idles high
- TX  output  1  serial out, idles high
- cmd  output  16  assembled command {high byte, low byte}
- cmd_rdy  output  1  full command valid; level signal
- clr_cmd_rdy  input  1  consumer acknowledges cmd
- resp  input  8  byte to transmit
- send_resp  input  1  one-cycle request to transmit resp
- resp_sent  output  1  one-cycle pulse when resp's stop bit completes
- tx_busy  output  1  high from accepted send_resp until resp_sent
- frm_err  output  1  one-cycle pulse when a received stop bit samples 0

Behaviour:
- Reset values when rst_n=0 at posedge clk: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, tx_busy=0, frm_err=0, both FSMs idle, assembler at HIGH.
- RX path:
  - RX passes through a 2-flop synchronizer preset to 1.
  - A start is a 1->0 transition on the synchronized RX while the receiver is idle.
  - Bits are sampled at mid-bit: first sample (start bit) at BAUD_DIV/2 after the edge, then every BAUD_DIV.
  - If the start-bit sample is 1, the start is spurious: return to idle, no byte.
  - 8 data bits, LSB first, then the stop bit. Stop=1 gives a valid byte; stop=0 pulses frm_err and discards the byte.
- Assembler FSM states: HIGH, LOW.
  - HIGH + valid byte: latch cmd[15:8], clear cmd_rdy the same cycle, go to LOW.
  - LOW + valid byte: latch cmd[7:0], set cmd_rdy the next cycle, go to HIGH.
  - A framing error in LOW returns to HIGH and leaves the high byte stale; cmd_rdy stays 0.
- cmd_rdy handling:
  - Cleared by clr_cmd_rdy.
  - If set and clear coincide, set wins.
  - cmd remains stable while cmd_rdy=1 until the next high byte lands.
- TX FSM states: IDLE, START, DATA, STOP.
  - send_resp in IDLE latches resp, raises tx_busy, drives START (TX=0) for BAUD_DIV cycles, then 8 data bits LSB first for BAUD_DIV each, then STOP (TX=1) for BAUD_DIV.
  - On the final STOP cycle: resp_sent pulses, tx_busy drops, return to IDLE.
  - send_resp while tx_busy is ignored (no queueing).
  - Total frame is 10*BAUD_DIV cycles from the send_resp cycle to resp_sent.
- RX and TX run independently; full duplex is allowed.
- A reset mid-frame aborts both paths immediately. TX returns high on the next edge and a partial RX byte is dropped.
- Baud counters are sized clog2(BAUD_DIV) and wrap cleanly. Bit counter is 4 bits.

Decomposition:
- Shared package (same package family as the bench tasks):
  - POS_ACK constant
  - default BAUD_DIV
  - typedefs for the assembler state {HIGH, LOW} and TX state {IDLE, START, DATA, STOP}
- One sub-module: uart_byte_rx, which contains the synchronizer, start detection, sampling, rx_data[7:0], rx_rdy and frm_err.
- The TX FSM and the assembler live in cmd_uart_responder.

Test Plan:
- BAUD_DIV=16, send bytes 8'h2C then 8'h7F on RX -> cmd=16'h2C7F; cmd_rdy rises within 2 clks after the second stop-bit sample; frm_err stays 0.
- With cmd_rdy=1, pulse clr_cmd_rdy -> cmd_rdy=0 next cycle, cmd unchanged. Then send high byte 8'h11 -> cmd[15:8]=8'h11 and cmd_rdy stays 0 until the low byte 8'h22 arrives -> 16'h1122.
- resp=8'hA5, pulse send_resp -> TX bit sequence 0,1,0,1,0,0,1,0,1,1 (one bit per 16 clks); resp_sent pulses exactly 160 clks after send_resp. A second send_resp at cycle 50 is ignored.
- Drive 8'h40 with stop bit forced 0 -> frm_err pulses once, assembler stays in HIGH. Following bytes 8'h00, 8'h05 -> cmd=16'h0005.
- 3-clk low glitch on RX -> no byte, no frm_err, cmd_rdy unchanged.
- Assert rst_n=0 during the fifth TX data bit and mid RX byte -> TX=1 and tx_busy=0 one clk later, cmd_rdy=0. After release, a fresh 2-byte command 8'hA0, 8'h01 yields cmd=16'hA001.

Source files
------------

// File: rtl/cmd_uart_responder_pkg.sv
// cmd_uart_responder_pkg: shared constants and state types for the serial command link
package cmd_uart_responder_pkg;
  localparam int BAUD_DIV_DEF = 5208;
  localparam logic [7:0] POS_ACK = 8'hA5;
  typedef enum logic {HIGH, LOW} asm_state_t;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/cmd_uart_responder_if.sv
// cmd_uart_responder_if: command-processor side of the UART responder
interface cmd_uart_responder_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;
  logic        frm_err;
  modport master (input cmd, cmd_rdy, resp_sent, tx_busy, frm_err, output clr_cmd_rdy, resp, send_resp);
  modport slave (output cmd, cmd_rdy, resp_sent, tx_busy, frm_err, input clr_cmd_rdy, resp, send_resp);
endinterface

// File: rtl/cmd_uart_responder_rx.sv
// uart_byte_rx: 8N1 byte receiver with synchronizer, mid-bit sampling and framing check
module uart_byte_rx
  import cmd_uart_responder_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       frm_err
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  rx_state_t state_q, state_nx;
  logic [2:0] sync_q;
  logic [CW-1:0] cnt_q;
  logic [3:0] bits_q;
  logic rx_s, fall, tick;
  // sync_q[1:0] is the synchronizer, sync_q[2] holds the previous synchronized level for edge detection
  assign rx_s = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = cnt_q == (state_q == RX_START ? HALF : FULL);
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      RX_IDLE:  if (fall) state_nx = RX_START;
      RX_START: if (tick) state_nx = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bits_q == 4'd7) state_nx = RX_STOP;
      RX_STOP:  if (tick) state_nx = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 3'b111;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx};
      state_q <= state_nx;
      cnt_q   <= (state_q == RX_IDLE || tick) ? '0 : cnt_q + 1'b1;
      bits_q  <= state_q != RX_DATA ? 4'd0 : tick ? bits_q + 4'd1 : bits_q;
      if (state_q == RX_DATA && tick) rx_data <= {rx_s, rx_data[7:1]};
      rx_rdy  <= state_q == RX_STOP && tick && rx_s;
      frm_err <= state_q == RX_STOP && tick && !rx_s;
    end
  end
endmodule

// File: rtl/cmd_uart_responder.sv
// cmd_uart_responder: pairs received UART bytes into 16-bit commands and transmits one-byte responses
module cmd_uart_responder
  import cmd_uart_responder_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  output logic TX,
  cmd_uart_responder_if.slave bus
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  logic [7:0] rx_data;
  logic rx_rdy, frm_err;
  asm_state_t asm_q, asm_nx;
  tx_state_t tx_q, tx_nx;
  logic [CW-1:0] cnt_q, cnt_nx;
  logic [3:0] bits_q, bits_nx;
  logic [7:0] data_q;
  logic [15:0] cmd_q;
  logic rdy_q, tick, tx_bit_nx;
  uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk(clk),
    .rst_n(rst_n),
    .rx(RX),
    .rx_data(rx_data),
    .rx_rdy(rx_rdy),
    .frm_err(frm_err)
  );
  assign tick = cnt_q == FULL;
  always_comb begin
    asm_nx = asm_q == HIGH ? (rx_rdy ? LOW : HIGH) : ((rx_rdy || frm_err) ? HIGH : LOW);
  end
  always_comb begin
    tx_nx = tx_q;
    unique case (tx_q)
      IDLE:  if (bus.send_resp) tx_nx = START;
      START: if (tick) tx_nx = DATA;
      DATA:  if (tick && bits_q == 4'd7) tx_nx = STOP;
      STOP:  if (tick) tx_nx = IDLE;
    endcase
    cnt_nx = (tx_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bits_nx = tx_q != DATA ? 4'd0 : tick ? bits_q + 4'd1 : bits_q;
    // TX is registered from the next state so the line never glitches between bits
    tx_bit_nx = tx_nx == START ? 1'b0 : tx_nx == DATA ? data_q[bits_nx[2:0]] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_q  <= HIGH;
      tx_q   <= IDLE;
      cnt_q  <= '0;
      bits_q <= '0;
      data_q <= '0;
      TX     <= 1'b1;
      cmd_q  <= '0;
      rdy_q  <= 1'b0;
    end else begin
      asm_q  <= asm_nx;
      tx_q   <= tx_nx;
      cnt_q  <= cnt_nx;
      bits_q <= bits_nx;
      TX     <= tx_bit_nx;
      if (tx_q == IDLE && bus.send_resp) data_q <= bus.resp;
      if (rx_rdy) cmd_q <= asm_q == HIGH ? {rx_data, cmd_q[7:0]} : {cmd_q[15:8], rx_data};
      rdy_q  <= (rx_rdy && asm_q == LOW) || (rdy_q && !bus.clr_cmd_rdy && !(rx_rdy && asm_q == HIGH));
    end
  end
  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = rdy_q;
  assign bus.resp_sent = tx_q == STOP && tick;
  assign bus.tx_busy   = tx_q != IDLE;
  assign bus.frm_err   = frm_err;
endmodule

// File: tb/tb_cmd_uart_responder.sv
// tb_cmd_uart_responder: randomized self-checking bench with a byte-level command model
module tb_cmd_uart_responder;
  import cmd_uart_responder_pkg::*;
  localparam int BD = 16;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, tx;
  cmd_uart_responder_if bus();
  cmd_uart_responder #(.BAUD_DIV(BD)) dut (.clk(clk), .rst_n(rst_n), .RX(rx), .TX(tx), .bus(bus.slave));
  always #5 clk = ~clk;
  int vectors = 0, fails = 0, cyc = 0, rise_cyc = -1, frm_cnt = 0, m_frm = 0;
  logic rdy_prev = 1'b0;
  logic [15:0] m_cmd = '0;
  logic m_rdy = 1'b0, m_low = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (bus.cmd_rdy === 1'b1 && !rdy_prev) rise_cyc = cyc;
    rdy_prev = bus.cmd_rdy;
    if (bus.frm_err === 1'b1) frm_cnt++;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (BD) @(negedge clk);
    end
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic model_byte(input logic [7:0] b, input logic stop);
    if (!stop) begin
      m_frm++;
      m_low = 1'b0;
    end else if (!m_low) begin
      m_cmd[15:8] = b;
      m_rdy = 1'b0;
      m_low = 1'b1;
    end else begin
      m_cmd[7:0] = b;
      m_rdy = 1'b1;
      m_low = 1'b0;
    end
  endtask
  task automatic rx_byte(input logic [7:0] b, input logic stop);
    send_byte(b, stop);
    model_byte(b, stop);
  endtask
  task automatic pulse_clr();
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; bus.clr_cmd_rdy = 1'b0; bus.resp = '0; bus.send_resp = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    vectors++; if (bus.cmd !== 16'h0) begin fails++; $display("FAIL reset_cmd: got %h want 0000", bus.cmd); end
    vectors++; if (bus.cmd_rdy !== 1'b0) begin fails++; $display("FAIL reset_cmd_rdy: got %b want 0", bus.cmd_rdy); end
    vectors++; if (bus.resp_sent !== 1'b0) begin fails++; $display("FAIL reset_resp_sent: got %b want 0", bus.resp_sent); end
    vectors++; if (bus.tx_busy !== 1'b0) begin fails++; $display("FAIL reset_tx_busy: got %b want 0", bus.tx_busy); end
    vectors++; if (bus.frm_err !== 1'b0) begin fails++; $display("FAIL reset_frm_err: got %b want 0", bus.frm_err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    int st;
    rx_byte(8'h2C, 1'b1);
    st = cyc;
    rx_byte(8'h7F, 1'b1);
    vectors++; if (bus.cmd !== 16'h2C7F) begin fails++; $display("FAIL basic_cmd: got %h want 2c7f", bus.cmd); end
    vectors++; if (bus.cmd_rdy !== 1'b1) begin fails++; $display("FAIL basic_cmd_rdy: got %b want 1", bus.cmd_rdy); end
    vectors++; if (frm_cnt !== 0) begin fails++; $display("FAIL basic_frm_err: got %0d pulses want 0", frm_cnt); end
    vectors++; if (rise_cyc - st < 150 || rise_cyc - st > 159) begin fails++; $display("FAIL basic_rdy_latency: got %0d want 150..159", rise_cyc - st); end
  endtask
  task automatic test_clear_reload();
    pulse_clr();
    vectors++; if (bus.cmd_rdy !== 1'b0) begin fails++; $display("FAIL clr_cmd_rdy: got %b want 0", bus.cmd_rdy); end
    vectors++; if (bus.cmd !== 16'h2C7F) begin fails++; $display("FAIL clr_cmd_stable: got %h want 2c7f", bus.cmd); end
    rx_byte(8'h11, 1'b1);
    vectors++; if (bus.cmd[15:8] !== 8'h11) begin fails++; $display("FAIL reload_high: got %h want 11", bus.cmd[15:8]); end
    vectors++; if (bus.cmd_rdy !== 1'b0) begin fails++; $display("FAIL reload_rdy_low: got %b want 0", bus.cmd_rdy); end
    rx_byte(8'h22, 1'b1);
    vectors++; if (bus.cmd !== 16'h1122) begin fails++; $display("FAIL reload_cmd: got %h want 1122", bus.cmd); end
    vectors++; if (bus.cmd_rdy !== 1'b1) begin fails++; $display("FAIL reload_rdy: got %b want 1", bus.cmd_rdy); end
  endtask
  task automatic test_tx(input logic [7:0] r, input bit dup);
    logic [9:0] f;
    int sent_at, extra;
    f = {1'b1, r, 1'b0};
    sent_at = -1;
    extra = 0;
    bus.resp = r;
    bus.send_resp = 1'b1;
    for (int k = 1; k <= 170; k++) begin
      @(negedge clk);
      if (k == 1) bus.send_resp = 1'b0;
      if (dup && k == 50) begin bus.resp = ~r; bus.send_resp = 1'b1; end
      if (dup && k == 51) bus.send_resp = 1'b0;
      if (k % BD == BD / 2 && k < 10 * BD) begin
        vectors++; if (tx !== f[k / BD]) begin fails++; $display("FAIL tx_bit%0d: got %b want %b (resp %h)", k / BD, tx, f[k / BD], r); end
      end
      if (bus.resp_sent === 1'b1) begin if (sent_at < 0) sent_at = k; else extra++; end
      if (k == 50) begin
        vectors++; if (bus.tx_busy !== 1'b1) begin fails++; $display("FAIL tx_busy_mid: got %b want 1", bus.tx_busy); end
      end
      if (k == 165) begin
        vectors++; if (bus.tx_busy !== 1'b0 || tx !== 1'b1) begin fails++; $display("FAIL tx_idle_after: got busy %b tx %b want 0 1", bus.tx_busy, tx); end
      end
    end
    vectors++; if (sent_at !== 10 * BD) begin fails++; $display("FAIL tx_resp_sent_time: got %0d want %0d", sent_at, 10 * BD); end
    vectors++; if (extra !== 0) begin fails++; $display("FAIL tx_resp_sent_extra: got %0d want 0", extra); end
  endtask
  task automatic test_frame_error();
    rx_byte(8'h40, 1'b0);
    vectors++; if (frm_cnt !== m_frm) begin fails++; $display("FAIL frm_err_count: got %0d want %0d", frm_cnt, m_frm); end
    vectors++; if (bus.cmd !== 16'h1122 || bus.cmd_rdy !== 1'b1) begin fails++; $display("FAIL frm_no_effect: got %h/%b want 1122/1", bus.cmd, bus.cmd_rdy); end
    rx_byte(8'h00, 1'b1);
    rx_byte(8'h05, 1'b1);
    vectors++; if (bus.cmd !== 16'h0005) begin fails++; $display("FAIL frm_recover_cmd: got %h want 0005", bus.cmd); end
    vectors++; if (bus.cmd_rdy !== 1'b1) begin fails++; $display("FAIL frm_recover_rdy: got %b want 1", bus.cmd_rdy); end
  endtask
  task automatic test_glitch();
    logic [7:0] a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BD) @(negedge clk);
    vectors++; if (frm_cnt !== m_frm) begin fails++; $display("FAIL glitch_frm_err: got %0d want %0d", frm_cnt, m_frm); end
    vectors++; if (bus.cmd !== m_cmd || bus.cmd_rdy !== m_rdy) begin fails++; $display("FAIL glitch_state: got %h/%b want %h/%b", bus.cmd, bus.cmd_rdy, m_cmd, m_rdy); end
    rx_byte(a, 1'b1);
    rx_byte(b, 1'b1);
    vectors++; if (bus.cmd !== {a, b}) begin fails++; $display("FAIL glitch_pair: got %h want %h", bus.cmd, {a, b}); end
  endtask
  task automatic test_random();
    logic [7:0] b;
    logic stop;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      stop = $urandom_range(0, 3) != 0;
      rx_byte(b, stop);
      vectors++; if (bus.cmd !== m_cmd) begin fails++; $display("FAIL rand%0d_cmd: got %h want %h", i, bus.cmd, m_cmd); end
      vectors++; if (bus.cmd_rdy !== m_rdy) begin fails++; $display("FAIL rand%0d_rdy: got %b want %b", i, bus.cmd_rdy, m_rdy); end
      vectors++; if (frm_cnt !== m_frm) begin fails++; $display("FAIL rand%0d_frm: got %0d want %0d", i, frm_cnt, m_frm); end
      if ($urandom_range(0, 2) == 0) begin
        pulse_clr();
        vectors++; if (bus.cmd_rdy !== 1'b0) begin fails++; $display("FAIL rand%0d_clr: got %b want 0", i, bus.cmd_rdy); end
      end
    end
  endtask
  task automatic test_full_duplex();
    logic [7:0] a, b, r;
    a = 8'($urandom);
    b = 8'($urandom);
    r = 8'($urandom);
    fork
      test_tx(r, 1'b0);
      begin
        rx_byte(a, 1'b1);
        rx_byte(b, 1'b1);
      end
    join
    vectors++; if (bus.cmd !== m_cmd || bus.cmd_rdy !== m_rdy) begin fails++; $display("FAIL duplex_cmd: got %h/%b want %h/%b", bus.cmd, bus.cmd_rdy, m_cmd, m_rdy); end
  endtask
  task automatic test_reset_mid_frame();
    logic [9:0] f;
    rx_byte(8'($urandom), 1'b1);
    if (!m_rdy) rx_byte(8'($urandom), 1'b1);
    vectors++; if (bus.cmd_rdy !== 1'b1) begin fails++; $display("FAIL rstmid_pre_rdy: got %b want 1", bus.cmd_rdy); end
    f = {1'b1, 8'h3C, 1'b0};
    bus.resp = 8'($urandom);
    bus.send_resp = 1'b1;
    for (int k = 0; k < 5 * BD + BD / 2; k++) begin
      rx = f[k / BD];
      if (k == 1) bus.send_resp = 1'b0;
      @(negedge clk);
    end
    vectors++; if (bus.tx_busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before: got %b want 1", bus.tx_busy); end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1 || bus.tx_busy !== 1'b0) begin fails++; $display("FAIL rstmid_tx: got tx %b busy %b want 1 0", tx, bus.tx_busy); end
    vectors++; if (bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'h0) begin fails++; $display("FAIL rstmid_cmd: got %h/%b want 0000/0", bus.cmd, bus.cmd_rdy); end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_cmd = '0; m_rdy = 1'b0; m_low = 1'b0;
    @(negedge clk);
    rx_byte(8'hA0, 1'b1);
    rx_byte(8'h01, 1'b1);
    vectors++; if (bus.cmd !== 16'hA001 || bus.cmd_rdy !== 1'b1) begin fails++; $display("FAIL rstmid_after: got %h/%b want a001/1", bus.cmd, bus.cmd_rdy); end
    vectors++; if (frm_cnt !== m_frm) begin fails++; $display("FAIL rstmid_frm: got %0d want %0d", frm_cnt, m_frm); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_clear_reload();
    test_tx(POS_ACK, 1'b1);
    test_frame_error();
    test_glitch();
    test_random();
    test_full_duplex();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
